// File: rtl/vram_arbiter.sv
// vram_arbiter
//
// Shares one synchronous single-port video RAM between the character-cell
// display fetch and a host port. Each 8-pixel character cell is split into
// eight slots taken from hpos[2:0]:
//   slot 0     : display fetch of the current cell's tile code (when visible)
//   slot 1..5  : host requests may be granted
//   slot 6, 7  : never granted, so a read granted at slot 5 completes at
//                slot 7 and the bus is always free for the next slot-0 fetch
//
// Optional feature (macro VRAM_ARB_STALL_COUNT_EN):
//   When defined, stall_count counts the cycles in which the host is
//   requesting in IDLE but cannot be granted. The count saturates at 16'hFFFF.
//   When undefined, stall_count is tied to zero.
//
// Ports
//   clk          : single clock, shared with the RAM
//   reset        : synchronous, active-high
//   hpos, vpos   : beam position from hvsync_generator
//   display_on   : visible-area flag
//   host_req     : host request, held with its command until host_ack
//   host_we      : 1 = write, 0 = read
//   host_addr    : host word address
//   host_wdata   : host write data
//   host_ack     : one-cycle completion pulse
//   host_rdata   : read result, held until the next read completes
//   ram_addr     : RAM address
//   ram_we       : RAM write enable
//   ram_din      : RAM write data
//   ram_dout     : RAM read data, one cycle after the address
//   tile_code    : word fetched for the current character cell
//   stall_count  : denied-request cycle counter

module vram_arbiter #(
    parameter  int ROW_BITS = 5,
    parameter  int COL_BITS = 5,
    parameter  int DATA_W   = 8,
    localparam int AW       = ROW_BITS + COL_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        hpos,
    input  logic [8:0]        vpos,
    input  logic              display_on,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [AW-1:0]     host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [AW-1:0]     ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] tile_code,
    output logic [15:0]       stall_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_ACK  = 2'd1,
        RD_WAIT = 2'd2,
        RD_ACK  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]    slot;
    logic [AW-1:0] disp_addr;
    logic          display_fetch;
    logic          slot_grantable;
    logic          grant;
    logic          fetch_pending;

    // Beam bits that do not take part in addressing.
    logic unused_beam_bits;
    assign unused_beam_bits = ^{hpos[8:COL_BITS+3], vpos[8:ROW_BITS+3], vpos[2:0]};

    assign slot      = hpos[2:0];
    assign disp_addr = {vpos[ROW_BITS+2:3], hpos[COL_BITS+2:3]};

    // Slot 0 is never grantable, so a display fetch and a host grant can never
    // coincide; the display owns the bus by construction.
    assign display_fetch  = (slot == 3'd0) && display_on;
    assign slot_grantable = (slot >= 3'd1) && (slot <= 3'd5);

    // Gating with reset keeps ram_we low from the very cycle reset asserts.
    assign grant = !reset && (state == IDLE) && host_req && slot_grantable;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the RAM/host strobes. With no host grant the address
    // defaults to the display address, which also serves the slot-0 fetch.
    always_comb begin
        state_next = state;
        ram_addr   = disp_addr;
        ram_we     = 1'b0;
        ram_din    = host_wdata;
        host_ack   = 1'b0;

        case (state)
            IDLE: begin
                if (grant) begin
                    ram_addr   = host_addr;
                    ram_we     = host_we;
                    state_next = host_we ? WR_ACK : RD_WAIT;
                end
            end
            WR_ACK: begin
                host_ack   = !reset;
                state_next = IDLE;
            end
            RD_WAIT: begin
                state_next = RD_ACK;
            end
            RD_ACK: begin
                host_ack   = !reset;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The RAM returns the fetched word during the slot-1 cycle after a fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pending <= 1'b0;
            tile_code     <= '0;
        end else begin
            fetch_pending <= display_fetch;
            if (fetch_pending && (slot == 3'd1)) begin
                tile_code <= ram_dout;
            end
        end
    end

    // Read data arrives during RD_WAIT and is held for the ack and beyond.
    always_ff @(posedge clk) begin
        if (reset) begin
            host_rdata <= '0;
        end else if (state == RD_WAIT) begin
            host_rdata <= ram_dout;
        end
    end

`ifdef VRAM_ARB_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= 16'h0000;
        end else if ((state == IDLE) && host_req && !grant && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//
// Directed bench for vram_arbiter with a one-cycle-latency RAM model.
// Inputs change 1 time unit after each rising clock edge and outputs are
// sampled at the following falling edge.

module tb_vram_arbiter;

    logic       clk;
    logic       reset;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       display_on;
    logic       host_req;
    logic       host_we;
    logic [9:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic [7:0] tile_code;
    logic [15:0] stall_count;

    logic [7:0] mem [1024] = '{default: 8'h00};

    int compare_count = 0;
    int fail_count    = 0;

    vram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .hpos        (hpos),
        .vpos        (vpos),
        .display_on  (display_on),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .tile_code   (tile_code),
        .stall_count (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM: write-through disabled, read data registered.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic applyStimulus(input logic rst, input logic [8:0] h, input logic [8:0] v,
                                 input logic de, input logic req, input logic we,
                                 input logic [9:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        reset      = rst;
        hpos       = h;
        vpos       = v;
        display_on = de;
        host_req   = req;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        #4;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset      = 1'b1;
        hpos       = '0;
        vpos       = '0;
        display_on = 1'b0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;

        // Reset state
        applyStimulus(1'b1, 9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        applyStimulus(1'b1, 9'd1, 9'd0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        checkOutput("rst_ack",   32'(host_ack),    32'h0);
        checkOutput("rst_rdata", 32'(host_rdata),  32'h00);
        checkOutput("rst_tile",  32'(tile_code),   32'h00);
        checkOutput("rst_stall", 32'(stall_count), 32'h0000);
        checkOutput("rst_we",    32'(ram_we),      32'h0);

        // Write 5A to 021 requested at slot 3
        applyStimulus(1'b0, 9'd3, 9'd0, 1'b0, 1'b1, 1'b1, 10'h021, 8'h5A);
        checkOutput("wr_we",    32'(ram_we),   32'h1);
        checkOutput("wr_addr",  32'(ram_addr), 32'h021);
        checkOutput("wr_din",   32'(ram_din),  32'h5A);
        checkOutput("wr_noack", 32'(host_ack), 32'h0);
        applyStimulus(1'b0, 9'd4, 9'd0, 1'b0, 1'b1, 1'b1, 10'h021, 8'h5A);
        checkOutput("wr_ack",    32'(host_ack), 32'h1);
        checkOutput("wr_ack_we", 32'(ram_we),   32'h0);
        applyStimulus(1'b0, 9'd5, 9'd0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        checkOutput("wr_ack_once", 32'(host_ack), 32'h0);

        // Read back 021 requested at slot 5, ack at slot 7
        applyStimulus(1'b0, 9'd13, 9'd0, 1'b0, 1'b1, 1'b0, 10'h021, 8'h00);
        checkOutput("rd_addr",  32'(ram_addr), 32'h021);
        checkOutput("rd_we",    32'(ram_we),   32'h0);
        applyStimulus(1'b0, 9'd14, 9'd0, 1'b0, 1'b1, 1'b0, 10'h021, 8'h00);
        checkOutput("rd_wait_ack", 32'(host_ack), 32'h0);
        applyStimulus(1'b0, 9'd15, 9'd0, 1'b0, 1'b1, 1'b0, 10'h021, 8'h00);
        checkOutput("rd_ack",   32'(host_ack),   32'h1);
        checkOutput("rd_rdata", 32'(host_rdata), 32'h5A);
        applyStimulus(1'b0, 9'd16, 9'd0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
        checkOutput("s0_addr",   32'(ram_addr),   32'h002);
        checkOutput("s0_we",     32'(ram_we),     32'h0);
        checkOutput("s0_ack",    32'(host_ack),   32'h0);
        checkOutput("rdata_hold", 32'(host_rdata), 32'h5A);

        // Store tile code 07 at {2,4}
        applyStimulus(1'b0, 9'd1, 9'd0, 1'b1, 1'b1, 1'b1, 10'h044, 8'h07);
        checkOutput("tw_we",   32'(ram_we),   32'h1);
        checkOutput("tw_addr", 32'(ram_addr), 32'h044);
        applyStimulus(1'b0, 9'd2, 9'd0, 1'b1, 1'b0, 1'b1, 10'h044, 8'h07);
        checkOutput("tw_ack", 32'(host_ack), 32'h1);

        // Display fetch at hpos 32 wins over a pending host write
        applyStimulus(1'b0, 9'd32, 9'd16, 1'b1, 1'b1, 1'b1, 10'h3FF, 8'hAA);
        checkOutput("fetch_addr", 32'(ram_addr), 32'h044);
        checkOutput("fetch_we",   32'(ram_we),   32'h0);
        applyStimulus(1'b0, 9'd33, 9'd16, 1'b1, 1'b1, 1'b1, 10'h3FF, 8'hAA);
        checkOutput("fetch_tile_early", 32'(tile_code), 32'h00);
        checkOutput("s1_grant_we",      32'(ram_we),    32'h1);
        checkOutput("s1_grant_addr",    32'(ram_addr),  32'h3FF);
        applyStimulus(1'b0, 9'd34, 9'd16, 1'b1, 1'b1, 1'b1, 10'h3FF, 8'hAA);
        checkOutput("fetch_tile", 32'(tile_code), 32'h07);
        checkOutput("s1_ack",     32'(host_ack),  32'h1);

        // Reset while a read is in RD_WAIT
        applyStimulus(1'b0, 9'd41, 9'd16, 1'b0, 1'b1, 1'b0, 10'h044, 8'h00);
        checkOutput("rr_addr", 32'(ram_addr), 32'h044);
        applyStimulus(1'b1, 9'd42, 9'd16, 1'b0, 1'b1, 1'b0, 10'h044, 8'h00);
        checkOutput("rr_ack_in_rst", 32'(host_ack), 32'h0);
        applyStimulus(1'b1, 9'd43, 9'd16, 1'b0, 1'b1, 1'b1, 10'h100, 8'h11);
        checkOutput("rr_no_we",  32'(ram_we),     32'h0);
        checkOutput("rr_no_ack", 32'(host_ack),   32'h0);
        checkOutput("rr_rdata",  32'(host_rdata), 32'h00);
        checkOutput("rr_tile",   32'(tile_code),  32'h00);
        applyStimulus(1'b0, 9'd44, 9'd16, 1'b0, 1'b1, 1'b1, 10'h100, 8'h11);
        checkOutput("rr_idle_we",   32'(ram_we),   32'h1);
        checkOutput("rr_idle_addr", 32'(ram_addr), 32'h100);
        applyStimulus(1'b0, 9'd45, 9'd16, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        checkOutput("rr_idle_ack", 32'(host_ack), 32'h1);

        // Request raised at slot 6 waits for slot 1 of the next cell
        applyStimulus(1'b0, 9'd46, 9'd16, 1'b0, 1'b1, 1'b1, 10'h200, 8'h33);
        checkOutput("blk6_we", 32'(ram_we), 32'h0);
        applyStimulus(1'b0, 9'd47, 9'd16, 1'b0, 1'b1, 1'b1, 10'h200, 8'h33);
        checkOutput("blk7_we", 32'(ram_we), 32'h0);
        applyStimulus(1'b0, 9'd48, 9'd16, 1'b0, 1'b1, 1'b1, 10'h200, 8'h33);
        checkOutput("blk0_we",   32'(ram_we),   32'h0);
        checkOutput("blk0_addr", 32'(ram_addr), 32'h046);
        checkOutput("blk0_din",  32'(ram_din),  32'h33);
        applyStimulus(1'b0, 9'd49, 9'd16, 1'b0, 1'b1, 1'b1, 10'h200, 8'h33);
        checkOutput("blk_grant_we",   32'(ram_we),   32'h1);
        checkOutput("blk_grant_addr", 32'(ram_addr), 32'h200);
`ifdef VRAM_ARB_STALL_COUNT_EN
        checkOutput("stall_3", 32'(stall_count), 32'h0003);
`else
        checkOutput("stall_off", 32'(stall_count), 32'h0000);
`endif
        applyStimulus(1'b0, 9'd50, 9'd16, 1'b0, 1'b0, 1'b1, 10'h200, 8'h33);
        checkOutput("blk_ack", 32'(host_ack), 32'h1);

`ifdef VRAM_ARB_STALL_COUNT_EN
        // Hold a request at slot 6 long enough to saturate the counter
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(1'b0, 9'd6, 9'd16, 1'b0, 1'b1, 1'b1, 10'h200, 8'h33);
        end
        checkOutput("stall_sat", 32'(stall_count), 32'h0000FFFF);
        applyStimulus(1'b0, 9'd6, 9'd16, 1'b0, 1'b1, 1'b1, 10'h200, 8'h33);
        applyStimulus(1'b0, 9'd6, 9'd16, 1'b0, 1'b1, 1'b1, 10'h200, 8'h33);
        checkOutput("stall_nowrap", 32'(stall_count), 32'h0000FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
